// File: rtl/mem_port_arbiter.sv
// Shares one 24b/16b memory port between fetch and data stage; data has priority (ARB_STARVE_GUARD_EN adds fetch starvation guard).
// Latency: grant at the first edge, WAIT_STATES+1 strobe cycles, then a one-cycle ack; one access per WAIT_STATES+3 cycles.
// Backpressure: requesters hold their request until ack; losers wait for the next IDLE cycle.
module mem_port_arbiter #(
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_re,
  input  logic [23:0] if_addr,
  output logic [15:0] if_data,
  output logic        if_ack,
  input  logic        ds_re,
  input  logic        ds_we,
  input  logic [23:0] ds_addr,
  input  logic [15:0] ds_wdata,
  output logic [15:0] ds_rdata,
  output logic        ds_ack,
  output logic        mem_re,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  typedef struct packed {
    logic        own_ds;
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
  } grant_t;

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("mem_port_arbiter: WAIT_STATES must be 0..15");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
  end

  state_t     state, state_nxt;
  grant_t     grant_q, grant_d;
  logic [3:0] wait_cnt;
  logic       ds_req;
  logic       take_if;
  logic       do_grant;
  logic       last_beat;

  assign ds_req    = ds_re | ds_we;
  assign do_grant  = (state == IDLE) && (ds_req || if_re);
  assign last_beat = (state == ACCESS) && (wait_cnt == 4'd0);

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  // Fetch is forced once data has won STARVE_LIMIT grants in a row over a pending fetch.
  assign take_if = if_re && (!ds_req || (starve_cnt == 4'(STARVE_LIMIT)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (do_grant) begin
      if (!take_if && if_re) starve_cnt <= starve_cnt + 4'd1;
      else                   starve_cnt <= 4'd0;
    end
  end
`else
  assign take_if = if_re && !ds_req;
`endif

  always_comb begin
    grant_d        = '0;
    grant_d.own_ds = !take_if;
    grant_d.we     = !take_if && ds_we;
    grant_d.addr   = take_if ? if_addr : ds_addr;
    grant_d.wdata  = ds_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ds_req || if_re) state_nxt = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_re = 1'b0;
    mem_we = 1'b0;
    if_ack = 1'b0;
    ds_ack = 1'b0;
    case (state)
      ACCESS: begin
        mem_re = !grant_q.we;
        mem_we = grant_q.we;
      end
      ACK: begin
        if_ack = !grant_q.own_ds;
        ds_ack = grant_q.own_ds;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q  <= '0;
      wait_cnt <= 4'd0;
      if_data  <= 16'd0;
      ds_rdata <= 16'd0;
    end else begin
      if (do_grant) begin
        grant_q  <= grant_d;
        wait_cnt <= 4'(WAIT_STATES);
      end else if ((state == ACCESS) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      // Read data lands only on the final access edge and only for reads.
      if (last_beat && !grant_q.we) begin
        if (grant_q.own_ds) ds_rdata <= mem_rdata;
        else                if_data  <= mem_rdata;
      end
    end
  end

  assign mem_addr  = grant_q.addr;
  assign mem_wdata = grant_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences, random traffic vs. a transaction-level model.
module tb_mem_port_arbiter;
  localparam int WS = 1;
  localparam int SL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_re = 1'b0;
  logic [23:0] if_addr = '0;
  logic [15:0] if_data;
  logic        if_ack;
  logic        ds_re = 1'b0;
  logic        ds_we = 1'b0;
  logic [23:0] ds_addr = '0;
  logic [15:0] ds_wdata = '0;
  logic [15:0] ds_rdata;
  logic        ds_ack;
  logic        mem_re;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.WAIT_STATES(WS), .STARVE_LIMIT(SL)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_re(if_re), .if_addr(if_addr), .if_data(if_data), .if_ack(if_ack),
    .ds_re(ds_re), .ds_we(ds_we), .ds_addr(ds_addr), .ds_wdata(ds_wdata),
    .ds_rdata(ds_rdata), .ds_ack(ds_ack),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    if_re = 0; ds_re = 0; ds_we = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_re"}, mem_re, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_if_ack"}, if_ack, 0);
    check({tag, "_ds_ack"}, ds_ack, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_if_data"}, if_data, 0);
    check({tag, "_ds_rdata"}, ds_rdata, 0);
  endtask

  typedef struct {
    logic i_re, d_re, d_we;
    logic e_none, e_ds, e_we;
  } vec_t;

  vec_t vt[8];
  logic [15:0] last_if_rd, last_ds_rd;

  // Transaction-level reference state for the random phase
  logic        m_busy, m_ds, m_we;
  logic [23:0] m_addr;
  logic [15:0] m_wdata, m_if_rd, m_ds_rd;
  int          m_k, m_starve;
  int          ack_c, ds_c, if_c, n_acks;
  logic        seq[$];
  logic        exp_seq[5];

  initial begin
    // ---------------- reset state ----------------
    rst_n = 0;
    step();
    step();
    check_all_zero("reset");
    rst_n = 1;
    last_if_rd = 0;
    last_ds_rd = 0;

    // ---------------- arbitration table ----------------
    //        i_re d_re d_we none ds  we
    vt[0] = '{1, 0, 0, 0, 0, 0};
    vt[1] = '{0, 1, 0, 0, 1, 0};
    vt[2] = '{0, 0, 1, 0, 1, 1};
    vt[3] = '{0, 1, 1, 0, 1, 1};
    vt[4] = '{1, 1, 0, 0, 1, 0};
    vt[5] = '{1, 0, 1, 0, 1, 1};
    vt[6] = '{1, 1, 1, 0, 1, 1};
    vt[7] = '{0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      if_re = vt[i].i_re; ds_re = vt[i].d_re; ds_we = vt[i].d_we;
      if_addr = 24'h111111; ds_addr = 24'h222222;
      ds_wdata = 16'h1000 + 16'(i); mem_rdata = 16'hC000 + 16'(i);
      step();
      if (vt[i].e_none) begin
        check("tbl_idle_re", mem_re, 0);
        check("tbl_idle_we", mem_we, 0);
        clear_inputs();
        continue;
      end
      for (int k = 0; k <= WS; k++) begin
        if (k > 0) step();
        check("tbl_mem_re", mem_re, !vt[i].e_we);
        check("tbl_mem_we", mem_we, vt[i].e_we);
        check("tbl_mem_addr", mem_addr, vt[i].e_ds ? 24'h222222 : 24'h111111);
        if (vt[i].e_we) check("tbl_mem_wdata", mem_wdata, 16'h1000 + 16'(i));
      end
      step();
      check("tbl_if_ack", if_ack, !vt[i].e_ds);
      check("tbl_ds_ack", ds_ack, vt[i].e_ds);
      if (!vt[i].e_ds) last_if_rd = 16'hC000 + 16'(i);
      else if (!vt[i].e_we) last_ds_rd = 16'hC000 + 16'(i);
      check("tbl_if_data", if_data, last_if_rd);
      check("tbl_ds_rdata", ds_rdata, last_ds_rd);
      clear_inputs();
      step();
      check("tbl_after_re", mem_re | mem_we | if_ack | ds_ack, 0);
    end

    // ---------------- single fetch, request held through ACK ----------------
    do_reset();
    if_re = 1; if_addr = 24'h001234; mem_rdata = 16'hBEEF;
    for (int k = 1; k <= WS + 1; k++) begin
      step();
      check("fetch_mem_re", mem_re, 1);
      check("fetch_mem_addr", mem_addr, 24'h001234);
    end
    step();
    check("fetch_ack", if_ack, 1);
    check("fetch_data", if_data, 16'hBEEF);
    check("fetch_ack_no_re", mem_re, 0);
    step();
    check("fetch_idle_re", mem_re, 0);
    check("fetch_idle_ack", if_ack, 0);
    step();
    check("fetch_regrant_re", mem_re, 1);
    if_re = 0;
    ack_c = 0;
    for (int k = 0; k < 2 * (WS + 3); k++) begin
      step();
      if (if_ack) ack_c++;
    end
    check("fetch_regrant_acks", ack_c, 1);

    // ---------------- data write ----------------
    ds_we = 1; ds_addr = 24'h00ABCD; ds_wdata = 16'h5A5A; mem_rdata = 16'h7777;
    for (int k = 1; k <= WS + 1; k++) begin
      step();
      check("wr_mem_we", mem_we, 1);
      check("wr_mem_re", mem_re, 0);
      check("wr_mem_addr", mem_addr, 24'h00ABCD);
      check("wr_mem_wdata", mem_wdata, 16'h5A5A);
    end
    step();
    check("wr_ds_ack", ds_ack, 1);
    check("wr_ack_no_we", mem_we, 0);
    check("wr_ds_rdata_kept", ds_rdata, 0);
    clear_inputs();
    step();

    // ---------------- simultaneous requests ----------------
    do_reset();
    if_re = 1; ds_re = 1; if_addr = 24'h000100; ds_addr = 24'h000200;
    ds_c = -1; if_c = -1;
    for (int c = 1; c <= 4 * (WS + 3); c++) begin
      step();
      if (ds_ack) begin ds_c = c; ds_re = 0; end
      if (if_ack) begin if_c = c; if_re = 0; end
    end
    check("sim_ds_ack_cycle", ds_c, WS + 2);
    check("sim_if_ack_cycle", if_c, ds_c + WS + 3);

    // ---------------- starvation ----------------
    do_reset();
`ifdef ARB_STARVE_GUARD_EN
    exp_seq = '{1, 1, 1, 0, 1};
`else
    exp_seq = '{1, 1, 1, 1, 1};
`endif
    seq.delete();
    ds_re = 1; if_re = 1;
    for (int c = 1; c <= 5 * (WS + 3); c++) begin
      step();
      if (ds_ack) seq.push_back(1'b1);
      if (if_ack) seq.push_back(1'b0);
    end
    clear_inputs();
    check("starve_ack_count", seq.size(), 5);
    for (int i = 0; i < 5; i++)
      check("starve_ack_owner", (i < seq.size()) ? seq[i] : 1'bx, exp_seq[i]);
    step(); step(); step(); step();

    // ---------------- reset mid-access ----------------
    ds_re = 1; ds_addr = 24'h00F00D; mem_rdata = 16'h4321;
    step();
    check("rst_mid_access_re", mem_re, 1);
    rst_n = 0;
    step();
    check_all_zero("rst_mid");
    rst_n = 1;
    clear_inputs();
    step();
    check("rst_mid_no_ack_next", ds_ack | if_ack, 0);

    // ---------------- random traffic vs. model ----------------
    do_reset();
    m_busy = 0; m_k = 0; m_starve = 0; m_if_rd = 0; m_ds_rd = 0;
    m_ds = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    for (int n = 0; n < 600; n++) begin
      logic in_strobe, in_ack, fetch_wins;
      in_strobe = m_busy && (m_k >= 1) && (m_k <= WS + 1);
      in_ack    = m_busy && (m_k == WS + 2);
      check("rnd_mem_re", mem_re, in_strobe && !m_we);
      check("rnd_mem_we", mem_we, in_strobe && m_we);
      if (in_strobe) check("rnd_mem_addr", mem_addr, m_addr);
      if (in_strobe && m_we) check("rnd_mem_wdata", mem_wdata, m_wdata);
      check("rnd_if_ack", if_ack, in_ack && !m_ds);
      check("rnd_ds_ack", ds_ack, in_ack && m_ds);
      check("rnd_if_data", if_data, m_if_rd);
      check("rnd_ds_rdata", ds_rdata, m_ds_rd);

      // Requesters: drop on ack, occasionally raise, scramble pins of the granted one.
      if (in_ack && !m_ds) if_re = 0;
      else if (!if_re && ($urandom_range(0, 2) == 0)) begin
        if_re = 1; if_addr = 24'($urandom);
      end
      if (in_ack && m_ds) begin ds_re = 0; ds_we = 0; end
      else if (!ds_re && !ds_we && ($urandom_range(0, 2) == 0)) begin
        case ($urandom_range(0, 2))
          0: begin ds_re = 1; ds_we = 0; end
          1: begin ds_re = 0; ds_we = 1; end
          default: begin ds_re = 1; ds_we = 1; end
        endcase
        ds_addr = 24'($urandom); ds_wdata = 16'($urandom);
      end
      if (m_busy && !in_ack) begin
        if (m_ds) begin ds_addr = 24'($urandom); ds_wdata = 16'($urandom); end
        else if_addr = 24'($urandom);
      end
      mem_rdata = 16'($urandom);

      // Model advance across the coming edge.
      if (m_busy) begin
        if (m_k == WS + 1 && !m_we) begin
          if (m_ds) m_ds_rd = mem_rdata;
          else      m_if_rd = mem_rdata;
        end
        if (m_k == WS + 2) m_busy = 0;
        else m_k++;
      end else if (if_re || ds_re || ds_we) begin
`ifdef ARB_STARVE_GUARD_EN
        fetch_wins = if_re && (!(ds_re || ds_we) || m_starve == SL);
        m_starve = (!fetch_wins && if_re) ? m_starve + 1 : 0;
`else
        fetch_wins = if_re && !(ds_re || ds_we);
`endif
        m_busy = 1; m_k = 1;
        m_ds = !fetch_wins;
        m_we = !fetch_wins && ds_we;
        m_addr = fetch_wins ? if_addr : ds_addr;
        m_wdata = ds_wdata;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
